msk_reg_pipe: RTL and testbench

MSK_REG_PIPE -- requirements
Module: msk_reg_pipe

---
 rtl/msk_reg_pipe.sv | 95 +++++++++
 tb/tb_msk_reg_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/msk_reg_pipe.sv
// Masked register pipeline: DEPTH handshaked stages carrying W*d-share words.
// Shares are only ever moved as whole words between registers, never combined.
module msk_reg_pipe #(
  parameter int d     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W*d-1:0]                 in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W*d-1:0]                 out,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int DW = W * d;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [CW-1:0]            count_q, count_d;

  logic [DEPTH-1:0] ready;
  logic             xfer_in;
  logic             xfer_out;

  // A stage can take a word if it or any later stage is empty, or the output drains.
  always_comb begin : ready_chain
    logic acc;
    acc   = out_ready;
    ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc      = acc | ~valid_q[k];
      ready[k] = acc;
    end
  end

  assign in_ready = ready[0] & ~clear & ~rst;
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = valid_q[DEPTH-1] & out_ready & ~clear;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    if (clear) begin
      valid_d = '0;
    end else begin
      if (ready[0]) valid_d[0] = xfer_in;
      for (int k = 1; k < DEPTH; k++) begin
        if (ready[k]) valid_d[k] = valid_q[k-1];
      end
    end

    // Data only moves when a valid word actually lands, so idle stages keep their contents.
    if (xfer_in) data_d[0] = in;
    for (int k = 1; k < DEPTH; k++) begin
      if (ready[k] && valid_q[k-1] && !clear) data_d[k] = data_q[k-1];
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({xfer_in, xfer_out})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out       = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_msk_reg_pipe.sv
// Directed bench for msk_reg_pipe with DEPTH=4, W=8, d=2.
module tb_msk_reg_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_w = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_w;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msk_reg_pipe #(.d(2), .W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .count     (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic ordy, input logic clr);
    in_valid  = v;
    in_w      = w;
    out_ready = ordy;
    clear     = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_out;
    int next_in;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out", out_w, 16'h0000);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    tick();
    checkOutput("rst_hold_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("release_in_ready", in_ready, 1'b1);

    // Single word, never stalled: appears after exactly DEPTH cycles
    applyStimulus(1'b1, 16'hA5C3, 1'b1, 1'b0);
    checkOutput("lat_in_ready", in_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("lat_count_c%0d", c), count, 3'd1);
      checkOutput($sformatf("lat_out_valid_c%0d", c), out_valid, (c == 4) ? 1'b1 : 1'b0);
      if (c == 4) checkOutput("lat_out", out_w, 16'hA5C3);
      tick();
    end
    checkOutput("empty_count", count, 3'd0);
    checkOutput("empty_out_valid", out_valid, 1'b0);
    checkOutput("empty_out_held", out_w, 16'hA5C3);

    // Fill with output stalled: only four words fit
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 1'b0, 1'b0);
      checkOutput($sformatf("fill_in_ready_%0d", i), in_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
    checkOutput("full_count", count, 3'd4);
    checkOutput("full_out_valid", out_valid, 1'b1);
    checkOutput("full_out", out_w, 16'd1);
    checkOutput("full_in_ready", in_ready, 1'b0);

    // Drain while still feeding 5 and 6; output must run 1..6 in order
    exp_out = 1;
    next_in = 5;
    for (int cyc = 0; cyc < 30 && exp_out <= 6; cyc++) begin
      applyStimulus(next_in <= 6, 16'(next_in), 1'b1, 1'b0);
      if (out_valid) begin
        checkOutput($sformatf("drain_word_%0d", exp_out), out_w, 32'(exp_out));
        exp_out++;
      end
      if (in_valid && in_ready) next_in++;
      tick();
    end
    checkOutput("drain_done", exp_out, 7);
    checkOutput("drain_count", count, 3'd0);

    // Full pipe streaming: one in and one out per cycle, count stays at DEPTH
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'h0014 + 16'(i), 1'b1, 1'b0);
      checkOutput($sformatf("stream_in_ready_%0d", i), in_ready, 1'b1);
      checkOutput($sformatf("stream_out_valid_%0d", i), out_valid, 1'b1);
      checkOutput($sformatf("stream_out_%0d", i), out_w, 16'h0010 + 16'(i));
      checkOutput($sformatf("stream_count_%0d", i), count, 3'd4);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput($sformatf("tail_out_%0d", i), out_w, 16'h001A + 16'(i));
      checkOutput($sformatf("tail_out_valid_%0d", i), out_valid, 1'b1);
      tick();
    end
    checkOutput("tail_count", count, 3'd0);
    checkOutput("tail_out_held", out_w, 16'h001D);

    // Clear with count=3 beats a simultaneous input and output handshake
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("pre_clear_count", count, 3'd3);
    checkOutput("pre_clear_out_valid", out_valid, 1'b0);
    applyStimulus(1'b1, 16'h0099, 1'b1, 1'b1);
    checkOutput("clear_in_ready", in_ready, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("clear_count", count, 3'd0);
    checkOutput("clear_out_valid", out_valid, 1'b0);
    checkOutput("clear_out_held", out_w, 16'h001D);
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0);
    checkOutput("post_clear_in_ready", in_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("post_clear_valid_c%0d", c), out_valid, (c == 4) ? 1'b1 : 1'b0);
      if (c == 4) checkOutput("post_clear_out", out_w, 16'h0040);
      tick();
    end

    // Asynchronous reset mid-flight with two words in the pipe
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("pre_rst_count", count, 3'd2);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_out", out_w, 16'h0000);
    checkOutput("mid_rst_count", count, 3'd0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    checkOutput("post_rst_out_valid", out_valid, 1'b0);
    applyStimulus(1'b1, 16'h0060, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("post_rst_valid_c%0d", c), out_valid, (c == 4) ? 1'b1 : 1'b0);
      if (c == 4) checkOutput("post_rst_out", out_w, 16'h0060);
      tick();
    end
    checkOutput("final_count", count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
